// File: rtl/register_n_shift.sv
// Parametrised universal shift register: shift, rotate, arithmetic shift, load, clear,
// plus a WIDTH-bit serial transmit sequence with BUSY/DONE handshake (full duplex on S_IN/S_OUT).
module register_n_shift #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [2:0]       MODO,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_SHIFT  = 3'b001,
    MODE_ROTATE = 3'b010,
    MODE_LOAD   = 3'b011,
    MODE_ARITH  = 3'b100,
    MODE_XMIT   = 3'b101,
    MODE_CLEAR  = 3'b110,
    MODE_RSVD   = 3'b111
  } modeType;

  typedef enum logic {
    IDLE = 1'b0,
    XMIT = 1'b1
  } stateType;

  stateType         state;
  logic             dirR;
  logic [CNT_W-1:0] counter;

  // Logical shift with S_IN fill is shared by mode 001 and every transmit cycle.
  logic             shiftDir;
  logic [WIDTH-1:0] shiftQ;
  logic             shiftOut;

  assign shiftDir = (state == XMIT) ? dirR : DIR;
  assign shiftQ   = shiftDir ? {Q[WIDTH-2:0], S_IN} : {S_IN, Q[WIDTH-1:1]};
  assign shiftOut = shiftDir ? Q[WIDTH-1] : Q[0];

  // NOTE: every register here is assigned with <= so all of them sample the pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      dirR    <= 1'b0;
      counter <= '0;
      Q       <= '0;
      S_OUT   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else if (ENB) begin
      DONE <= 1'b0;
      if (state == XMIT) begin
        Q       <= shiftQ;
        S_OUT   <= shiftOut;
        counter <= counter - CNT_W'(1);
        if (counter == CNT_W'(1)) begin
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= IDLE;
        end
      end else begin
        case (modeType'(MODO))
          MODE_SHIFT: begin
            Q     <= shiftQ;
            S_OUT <= shiftOut;
          end
          MODE_ROTATE: begin
            if (DIR) begin
              Q     <= {Q[WIDTH-2:0], Q[WIDTH-1]};
              S_OUT <= Q[WIDTH-1];
            end else begin
              Q     <= {Q[0], Q[WIDTH-1:1]};
              S_OUT <= Q[0];
            end
          end
          MODE_LOAD: Q <= D;
          MODE_ARITH: begin
            if (DIR) begin
              Q     <= {Q[WIDTH-2:0], 1'b0};
              S_OUT <= Q[WIDTH-1];
            end else begin
              Q     <= {Q[WIDTH-1], Q[WIDTH-1:1]};
              S_OUT <= Q[0];
            end
          end
          MODE_XMIT: begin
            Q       <= D;
            dirR    <= DIR;
            counter <= CNT_W'(WIDTH);
            BUSY    <= 1'b1;
            state   <= XMIT;
          end
          MODE_CLEAR: Q <= '0;
          default: ;  // hold and reserved
        endcase
      end
    end
  end

endmodule

// File: tb/tb_register_n_shift.sv
// Bench for register_n_shift: a 4-bit and an 8-bit instance share control inputs and are
// compared every cycle against an arithmetic reference model, plus directed scenarios.
module tb_register_n_shift;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ENB = 1'b0;
  logic       DIR = 1'b0;
  logic       S_IN = 1'b0;
  logic [2:0] MODO = 3'b000;
  logic [3:0] d4 = '0;
  logic [7:0] d8 = '0;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       sOut4, busy4, done4;
  logic       sOut8, busy8, done8;

  int nChecks = 0;
  int nErrors = 0;

  // reference model state, index 0 = 4-bit instance, 1 = 8-bit instance
  int unsigned mQ[2];
  bit          mOut[2];
  bit          mBusy[2];
  bit          mDone[2];
  bit          mDir[2];
  int          mLeft[2];

  register_n_shift #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO),
    .D(d4), .Q(q4), .S_OUT(sOut4), .BUSY(busy4), .DONE(done4)
  );

  register_n_shift #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO),
    .D(d8), .Q(q8), .S_OUT(sOut8), .BUSY(busy8), .DONE(done8)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mQ[i] = 0; mOut[i] = 0; mBusy[i] = 0; mDone[i] = 0; mDir[i] = 0; mLeft[i] = 0;
    end
  endtask

  task automatic modelShift(input int i, input int w, input bit left, input bit fill);
    int unsigned mask = (32'd1 << w) - 1;
    if (left) begin
      mOut[i] = mQ[i][w-1];
      mQ[i]   = ((mQ[i] * 2) + fill) & mask;
    end else begin
      mOut[i] = mQ[i][0];
      mQ[i]   = (mQ[i] / 2) + (int'(fill) << (w - 1));
    end
  endtask

  task automatic modelStep(input int i, input int w, input int unsigned d);
    int unsigned mask = (32'd1 << w) - 1;
    bit msbBit;
    if (!ENB) return;
    mDone[i] = 0;
    if (mBusy[i]) begin
      modelShift(i, w, mDir[i], S_IN);
      mLeft[i]--;
      if (mLeft[i] == 0) begin
        mBusy[i] = 0;
        mDone[i] = 1;
      end
    end else begin
      msbBit = mQ[i][w-1];
      case (MODO)
        3'd1: modelShift(i, w, DIR, S_IN);
        3'd2: modelShift(i, w, DIR, DIR ? msbBit : mQ[i][0]);
        3'd3: mQ[i] = d & mask;
        3'd4: modelShift(i, w, DIR, DIR ? 1'b0 : msbBit);
        3'd5: begin
          mQ[i] = d & mask; mDir[i] = DIR; mLeft[i] = w; mBusy[i] = 1;
        end
        3'd6: mQ[i] = 0;
        default: ;
      endcase
    end
  endtask

  task automatic compareAll(input string tag);
    check({tag, ".q4"},    q4,    mQ[0]);
    check({tag, ".sout4"}, sOut4, mOut[0]);
    check({tag, ".busy4"}, busy4, mBusy[0]);
    check({tag, ".done4"}, done4, mDone[0]);
    check({tag, ".q8"},    q8,    mQ[1]);
    check({tag, ".sout8"}, sOut8, mOut[1]);
    check({tag, ".busy8"}, busy8, mBusy[1]);
    check({tag, ".done8"}, done8, mDone[1]);
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic tick(input string tag);
    @(posedge CLK);
    modelStep(0, 4, d4);
    modelStep(1, 8, d8);
    #1;
    compareAll(tag);
  endtask

  logic [3:0] rotQ[4]   = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
  logic       rotOut[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       xPat[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       xOut[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic       bOut[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int edges;
    logic [3:0] stream;
    modelReset();
    repeat (2) @(posedge CLK);
    #3;
    compareAll("reset");
    RESET_N = 1'b1;
    ENB = 1'b1;

    // rotate left on the 4-bit instance
    MODO = 3'b011; d4 = 4'b1001; d8 = 8'h90;
    tick("load");
    MODO = 3'b010; DIR = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick("rot");
      check($sformatf("rot_q[%0d]", k), q4, rotQ[k]);
      check($sformatf("rot_out[%0d]", k), sOut4, rotOut[k]);
    end

    // arithmetic shifts on the 8-bit instance
    MODO = 3'b011;
    tick("load8");
    MODO = 3'b100; DIR = 1'b0;
    tick("asr");
    check("asr1_q8", q8, 8'hC8); check("asr1_out", sOut8, 0);
    tick("asr");
    check("asr2_q8", q8, 8'hE4); check("asr2_out", sOut8, 0);
    DIR = 1'b1;
    tick("asl");
    check("asl_q8", q8, 8'hC8); check("asl_out", sOut8, 1);

    // transmit 1101 MSB first, then back-to-back transmit of 0011 on the DONE cycle
    MODO = 3'b101; DIR = 1'b1; d4 = 4'b1101; d8 = 8'hA5;
    tick("xstart");
    check("x_busy_start", busy4, 1);
    MODO = 3'b000; DIR = 1'b0;
    for (int k = 0; k < 4; k++) begin
      S_IN = xPat[k];
      tick("xmit");
      check($sformatf("x_out[%0d]", k), sOut4, xOut[k]);
      check($sformatf("x_busy[%0d]", k), busy4, k < 3);
      check($sformatf("x_done[%0d]", k), done4, k == 3);
    end
    check("x_final_q", q4, 4'b0110);
    MODO = 3'b101; DIR = 1'b1; d4 = 4'b0011; S_IN = 1'b0;
    tick("b2b_start");
    check("b2b_busy", busy4, 1); check("b2b_done", done4, 0);
    MODO = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tick("b2b");
      check($sformatf("b2b_out[%0d]", k), sOut4, bOut[k]);
    end
    check("b2b_done_end", done4, 1);
    tick("b2b_clr");
    check("done_clear", done4, 0);
    repeat (8) tick("drain");

    // paused transmit: ENB low for 3 cycles after the second shift
    MODO = 3'b101; DIR = 1'b1; d4 = 4'b1101; S_IN = 1'b0;
    tick("pstart");
    MODO = 3'b000;
    edges = 0; stream = '0;
    for (int k = 0; k < 2; k++) begin
      tick("pshift"); edges++; stream = {stream[2:0], sOut4};
    end
    ENB = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick("pause"); edges++;
      check("pause_q", q4, 4'b0100); check("pause_busy", busy4, 1);
      check("pause_out", sOut4, 1);
    end
    ENB = 1'b1;
    while (!done4 && edges < 20) begin
      tick("presume"); edges++; stream = {stream[2:0], sOut4};
    end
    check("pause_len", edges, 7);
    check("pause_stream", stream, 4'b1101);
    repeat (8) tick("drain2");

    // asynchronous reset mid-transmit (counter=2, Q=1010)
    MODO = 3'b101; DIR = 1'b1; d4 = 4'b0110;
    tick("rstart");
    MODO = 3'b000; S_IN = 1'b1;
    tick("rshift");
    S_IN = 1'b0;
    tick("rshift");
    check("pre_rst_q", q4, 4'b1010); check("pre_rst_busy", busy4, 1);
    #3;
    RESET_N = 1'b0;
    modelReset();
    #1;
    check("arst_q", q4, 0); check("arst_out", sOut4, 0);
    check("arst_busy", busy4, 0); check("arst_done", done4, 0);
    compareAll("arst");
    @(posedge CLK); #3;
    compareAll("arst_hold");
    RESET_N = 1'b1;

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      ENB  = ($urandom_range(7) != 0);
      MODO = 3'($urandom_range(7));
      DIR  = 1'($urandom_range(1));
      S_IN = 1'($urandom_range(1));
      d4   = 4'($urandom);
      d8   = 8'($urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/register_n_shift.md
Name: register_n_shift

Overview:
- Parametrised next-generation universal shift register, successor to the fixed 4-bit, 2-bit-mode register.
- Adds generic WIDTH, a 3-bit mode, rotate, arithmetic shift and clear.
- Adds a multi-cycle serial-transmit sequence with BUSY/DONE handshake, so a word can be serialised to S_OUT while S_IN is shifted in (full duplex).
- Sits in the same datapath slot as the 4-bit register; the existing 5-instance bench structure is reused.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter; derived, not to be overridden.

Ports:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous, active-low reset
- ENB  input  1  enable; 0 freezes all state (including mid-transmit)
- DIR  input  1  1 = shift toward MSB (left), 0 = shift toward LSB (right)
- S_IN  input  1  serial data in
- MODO  input  3  operation mode
- D  input  WIDTH  parallel load data
- Q  output  WIDTH  register contents
- S_OUT  output  1  last bit shifted or rotated out (registered)
- BUSY  output  1  serial transmit in progress
- DONE  output  1  one-cycle pulse at transmit completion

Behaviour:
- Reset (RESET_N=0, async, any time including mid-transmit): Q=0, S_OUT=0, BUSY=0, DONE=0, counter=0, FSM=IDLE. Release is synchronous to the next CLK edge.
- All updates occur on the CLK rising edge, only when ENB=1. With ENB=0 every register holds, and DONE holds its previous value.
- FSM states: IDLE and XMIT.
- IDLE mode decode (ENB=1):
  - 000 hold: Q and S_OUT unchanged.
  - 001 logical shift: left gives Q<={Q[W-2:0],S_IN}, S_OUT<=Q[W-1]; right gives Q<={S_IN,Q[W-1:1]}, S_OUT<=Q[0].
  - 010 rotate: left gives Q<={Q[W-2:0],Q[W-1]}, S_OUT<=Q[W-1]; right gives Q<={Q[0],Q[W-1:1]}, S_OUT<=Q[0]. S_IN is ignored.
  - 011 parallel load: Q<=D; S_OUT unchanged.
  - 100 arithmetic shift: right gives Q<={Q[W-1],Q[W-1:1]}, S_OUT<=Q[0]; left gives Q<={Q[W-2:0],1'b0}, S_OUT<=Q[W-1].
  - 101 start transmit: Q<=D, DIR latched into dir_r, counter<=WIDTH, BUSY<=1, FSM goes to XMIT. S_OUT unchanged.
  - 110 clear: Q<=0; S_OUT unchanged.
  - 111 reserved: behaves as hold.
- XMIT (ENB=1):
  - Each cycle performs a logical shift in direction dir_r with S_IN fill, updates S_OUT as for mode 001, and decrements the counter.
  - MODO, DIR and D are ignored while BUSY=1.
  - On the edge where the counter goes 1 to 0: BUSY<=0, DONE<=1, FSM returns to IDLE.
  - After the start edge there are exactly WIDTH shift edges; S_OUT presents D bits in MSB-first (left) or LSB-first (right) order.
  - After those WIDTH shifts, Q holds the WIDTH S_IN bits received.
- DONE is high for exactly one enabled cycle and clears on the next ENB=1 edge.
  - A new transmit (MODO=101) may be issued on that same edge; BUSY then re-asserts and DONE clears.
- ENB=0 during XMIT pauses the sequence without losing a bit; the counter and BUSY are held.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=4. Reset asserted mid-XMIT (counter=2, Q=4'b1010) -> Q=0, S_OUT=0, BUSY=0, DONE=0 immediately, without waiting for a clock edge.
- WIDTH=4, Q=4'b1001, MODO=010, DIR=1, 4 edges -> Q sequence 0011, 0110, 1100, 1001; S_OUT sequence 1, 0, 0, 1.
- WIDTH=8, Q=8'h90, MODO=100, DIR=0, 2 edges -> Q=8'hC8 then 8'hE4; S_OUT=0, 0. Then DIR=1, 1 edge -> Q=8'hC8, S_OUT=1.
- WIDTH=4, D=4'b1101, MODO=101, DIR=1, S_IN pattern 0,1,1,0 -> S_OUT sequence 1, 1, 0, 1; BUSY high for 4 shift edges; DONE=1 for exactly 1 cycle; final Q=4'b0110.
- WIDTH=4 transmit with ENB=0 held for 3 cycles after the 2nd shift -> Q, S_OUT, counter and BUSY frozen; completion is delayed by exactly 3 cycles; the bit stream is identical to the unpaused run.
- WIDTH=4, MODO=101 issued on the DONE cycle with D=4'b0011 -> back-to-back transmit: BUSY=1 on the next edge, DONE=0, S_OUT bits 0, 0, 1, 1.
